// File: rtl/hyperbus_target.sv
// HyperBus responder: decodes the 48-bit CA, applies a fixed doubled initial latency
// and serves linear or wrapped word bursts from internal memory, plus the CR0 register.
module hyperbus_target #(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 6,
    parameter logic [15:0] CR0_RESET = 16'h8F1F
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       hyper_cs_ni,
    input  logic       hyper_ck_i,
    input  logic       hyper_reset_ni,
    input  logic [7:0] hyper_dq_i,
    output logic [7:0] hyper_dq_o,
    output logic       hyper_dq_oe_o,
    input  logic       hyper_rwds_i,
    output logic       hyper_rwds_o,
    output logic       hyper_rwds_oe_o,
    output logic [15:0] cfg_cr0_o
);
    localparam int AW       = $clog2(MEM_WORDS);
    localparam int LAST_LAT = 6 + 4 * LATENCY - 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CA     = 3'd1,
        S_LAT    = 3'd2,
        S_WDATA  = 3'd3,
        S_RDATA  = 3'd4,
        S_REGW   = 3'd5,
        S_WAITCS = 3'd6
    } state_e;

    state_e        state_q, state_d;
    logic          ck_q;
    logic [7:0]    e_q, e_d;
    logic [47:0]   ca_q, ca_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          bi_q, bi_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_mask_q, hold_mask_d;
    logic [15:0]   cr0_q, cr0_d;
    logic [7:0]    dq_q, dq_d;
    logic          dq_oe_q, dq_oe_d;
    logic          rwds_q, rwds_d;
    logic          rwds_oe_q, rwds_oe_d;
    logic [15:0]   rword_q;
    logic [15:0]   mem_q [MEM_WORDS];

    logic          cs_s, edge_s, last_ca_s, last_lat_s;
    logic [47:0]   ca_full_s;
    logic [31:0]   ca_word_s;
    logic [AW-1:0] ca_addr_s, addr_next_s, rd_addr_s;
    logic          rd_en_s, we_hi_s, we_lo_s;
    logic [15:0]   src_word_s;
    logic          unused_ok_s;

    assign cs_s        = ~hyper_cs_ni;
    assign edge_s      = (hyper_ck_i != ck_q) && cs_s;
    assign last_ca_s   = (state_q == S_CA) && edge_s && (e_q == 8'd5);
    assign last_lat_s  = (state_q == S_LAT) && edge_s && (e_q == 8'(LAST_LAT));
    // CA is shifted in MSB byte first; after the sixth byte the first one sits in [47:40]
    assign ca_full_s   = {ca_q[39:0], hyper_dq_i};
    assign ca_word_s   = {ca_full_s[44:16], ca_full_s[2:0]};
    assign ca_addr_s   = ca_word_s[AW-1:0];
    assign addr_next_s = ca_q[45] ? (addr_q + AW'(1)) : {addr_q[AW-1:4], addr_q[3:0] + 4'd1};
    assign src_word_s  = ca_q[46] ? cr0_q : rword_q;
    assign unused_ok_s = ^{ca_word_s[31:AW], ca_full_s[15:3], ca_q[44:40]};

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; CS rise or bus reset always returns to IDLE
    always_comb begin
        state_d = state_q;
        if (!hyper_reset_ni || !cs_s) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_CA;
                S_CA:    state_d = last_ca_s ? ((ca_full_s[46] && !ca_full_s[47]) ? S_REGW : S_LAT) : S_CA;
                S_LAT:   state_d = last_lat_s ? (ca_q[47] ? S_RDATA : S_WDATA) : S_LAT;
                S_REGW:  state_d = (edge_s && bi_q) ? S_WAITCS : S_REGW;
                default: state_d = state_q;
            endcase
        end
    end

    // Datapath and registered bus outputs
    always_comb begin
        e_d         = e_q;
        ca_d        = ca_q;
        addr_d      = addr_q;
        bi_d        = bi_q;
        hold_d      = hold_q;
        hold_mask_d = hold_mask_q;
        cr0_d       = cr0_q;
        dq_d        = dq_q;
        dq_oe_d     = dq_oe_q;
        rwds_d      = rwds_q;
        rwds_oe_d   = rwds_oe_q;
        rd_en_s     = 1'b0;
        rd_addr_s   = addr_q;
        we_hi_s     = 1'b0;
        we_lo_s     = 1'b0;
        if (!cs_s) begin
            e_d       = 8'd0;
            bi_d      = 1'b0;
            dq_d      = 8'd0;
            dq_oe_d   = 1'b0;
            rwds_d    = 1'b0;
            rwds_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    e_d       = 8'd0;
                    bi_d      = 1'b0;
                    dq_oe_d   = 1'b0;
                    rwds_d    = 1'b1;
                    rwds_oe_d = 1'b1;
                end
                S_CA: begin
                    rwds_d    = 1'b1;
                    rwds_oe_d = 1'b1;
                    if (edge_s) begin
                        e_d    = e_q + 8'd1;
                        ca_d   = ca_full_s;
                        addr_d = last_ca_s ? ca_addr_s : addr_q;
                    end else begin
                        e_d = e_q;
                    end
                end
                S_LAT: begin
                    rd_en_s   = 1'b1;
                    dq_oe_d   = 1'b0;
                    rwds_d    = 1'b0;
                    rwds_oe_d = 1'b0;
                    e_d       = edge_s ? (e_q + 8'd1) : e_q;
                    // Byte 0 is launched on the last latency edge so it is valid at the first data edge
                    if (last_lat_s && ca_q[47]) begin
                        dq_d      = src_word_s[15:8];
                        rwds_d    = 1'b1;
                        dq_oe_d   = 1'b1;
                        rwds_oe_d = 1'b1;
                        bi_d      = 1'b1;
                    end else begin
                        bi_d = 1'b0;
                    end
                end
                S_RDATA: begin
                    if (edge_s) begin
                        dq_d   = bi_q ? src_word_s[7:0] : src_word_s[15:8];
                        rwds_d = ~bi_q;
                        bi_d   = ~bi_q;
                        if (bi_q && !ca_q[46]) begin
                            addr_d    = addr_next_s;
                            rd_en_s   = 1'b1;
                            rd_addr_s = addr_next_s;
                        end else begin
                            addr_d = addr_q;
                        end
                    end else begin
                        bi_d = bi_q;
                    end
                end
                S_WDATA: begin
                    dq_oe_d   = 1'b0;
                    rwds_oe_d = 1'b0;
                    if (edge_s && !bi_q) begin
                        hold_d      = hyper_dq_i;
                        hold_mask_d = hyper_rwds_i;
                        bi_d        = 1'b1;
                    end else if (edge_s) begin
                        we_hi_s = ~hold_mask_q;
                        we_lo_s = ~hyper_rwds_i;
                        addr_d  = addr_next_s;
                        bi_d    = 1'b0;
                    end else begin
                        bi_d = bi_q;
                    end
                end
                S_REGW: begin
                    dq_oe_d   = 1'b0;
                    rwds_oe_d = 1'b0;
                    if (edge_s && !bi_q) begin
                        hold_d = hyper_dq_i;
                        bi_d   = 1'b1;
                    end else if (edge_s) begin
                        cr0_d = {hold_q, hyper_dq_i};
                        bi_d  = 1'b0;
                    end else begin
                        bi_d = bi_q;
                    end
                end
                default: begin
                    dq_oe_d   = 1'b0;
                    rwds_oe_d = 1'b0;
                end
            endcase
        end
        // Bus reset: everything but memory returns to reset values, pending writes are dropped
        if (!hyper_reset_ni) begin
            e_d         = 8'd0;
            ca_d        = 48'd0;
            addr_d      = '0;
            bi_d        = 1'b0;
            hold_d      = 8'd0;
            hold_mask_d = 1'b0;
            cr0_d       = CR0_RESET;
            dq_d        = 8'd0;
            dq_oe_d     = 1'b0;
            rwds_d      = 1'b0;
            rwds_oe_d   = 1'b0;
            we_hi_s     = 1'b0;
            we_lo_s     = 1'b0;
        end else begin
            rd_en_s = rd_en_s;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ck_q        <= 1'b0;
            e_q         <= 8'd0;
            ca_q        <= 48'd0;
            addr_q      <= '0;
            bi_q        <= 1'b0;
            hold_q      <= 8'd0;
            hold_mask_q <= 1'b0;
            cr0_q       <= CR0_RESET;
            dq_q        <= 8'd0;
            dq_oe_q     <= 1'b0;
            rwds_q      <= 1'b0;
            rwds_oe_q   <= 1'b0;
        end else begin
            ck_q        <= hyper_ck_i;
            e_q         <= e_d;
            ca_q        <= ca_d;
            addr_q      <= addr_d;
            bi_q        <= bi_d;
            hold_q      <= hold_d;
            hold_mask_q <= hold_mask_d;
            cr0_q       <= cr0_d;
            dq_q        <= dq_d;
            dq_oe_q     <= dq_oe_d;
            rwds_q      <= rwds_d;
            rwds_oe_q   <= rwds_oe_d;
        end
    end

    // Word memory with per-byte write enables and registered read port
    always_ff @(posedge clk_i) begin
        if (we_hi_s) begin
            mem_q[addr_q][15:8] <= hold_q;
        end
        if (we_lo_s) begin
            mem_q[addr_q][7:0] <= hyper_dq_i;
        end
        if (rd_en_s) begin
            rword_q <= mem_q[rd_addr_s];
        end
    end

    assign hyper_dq_o      = dq_q;
    assign hyper_dq_oe_o   = dq_oe_q;
    assign hyper_rwds_o    = rwds_q;
    assign hyper_rwds_oe_o = rwds_oe_q;
    assign cfg_cr0_o       = cr0_q;

endmodule

// File: doc/hyperbus_target.md
Name: hyperbus_target

Overview:
Synthesizable HyperBus responder (HyperRAM-like target) for the far end of the `hyperbus` controller's physical interface. It is used in loopback benches and on-chip self-test.
- Decodes the 48-bit command/address (CA), applies fixed 2x initial latency, then serves linear or wrapped word bursts from an internal 16-bit memory.
- Holds one config register, CR0.
- `clk_i` runs at twice the HyperBus CK rate. Each `hyper_ck_i` edge is detected synchronously and carries one byte.

Parameters:
MEM_WORDS, 1024, memory depth in 16-bit words (power of two).
LATENCY, 6, initial latency in CK cycles (always applied doubled).
CR0_RESET, 16'h8F1F, CR0 reset value.

Ports:
clk_i  input  1  system clock, 2x CK rate
rst_ni  input  1  asynchronous active-low reset
hyper_cs_ni  input  1  chip select, active low
hyper_ck_i  input  1  HyperBus CK from controller
hyper_reset_ni  input  1  bus reset, active low, sampled on clk_i
hyper_dq_i  input  8  DQ from controller
hyper_dq_o  output  8  DQ to controller
hyper_dq_oe_o  output  1  DQ output enable
hyper_rwds_i  input  1  RWDS from controller (write byte mask)
hyper_rwds_o  output  1  RWDS to controller
hyper_rwds_oe_o  output  1  RWDS output enable
cfg_cr0_o  output  16  current CR0 value

Behaviour:
- Clock and reset: one clock `clk_i`, reset `rst_ni` asynchronous active-low.
- Reset values: `hyper_dq_o`=0, `hyper_dq_oe_o`=0, `hyper_rwds_o`=0, `hyper_rwds_oe_o`=0, CR0=CR0_RESET, FSM=IDLE. Memory contents are not reset.
- `hyper_reset_ni`=0: same effect as reset on the next clk_i edge, except memory is kept.
- Edge detect:
  - `ck_q` is `hyper_ck_i` registered.
  - An edge occurs in any cycle with `hyper_ck_i != ck_q` while `hyper_cs_ni`=0.
  - Edge counter `e` is cleared in IDLE. The first edge after CS falls is e=0.
- FSM states: IDLE, CA, LAT, WDATA, RDATA, REGW, WAITCS.
  - IDLE -> CA on CS=0.
  - CA: capture `hyper_dq_i` on edges 0..5, MSB byte first, into `ca[47:40]`..`ca[7:0]`.
  - CA fields:
    - `ca[47]`: 1=read.
    - `ca[46]`: 1=register space.
    - `ca[45]`: 1=linear, 0=wrapped.
    - Word address = `{ca[44:16],ca[2:0]}` modulo MEM_WORDS.
  - After edge 5:
    - register write -> REGW;
    - otherwise -> LAT.
  - LAT: count 4*LATENCY edges, then:
    - read -> RDATA;
    - write -> WDATA.
  - REGW (zero latency): bytes on the next two edges form `{b0,b1}`. CR0 is loaded on the second byte, then -> WAITCS.
  - WAITCS: ignore all edges until CS=1.
- RWDS during CA:
  - `hyper_rwds_oe_o`=1 and `hyper_rwds_o`=1 (fixed 2x latency) from CS fall until the cycle after edge 5.
  - Outside CA and RDATA: `hyper_rwds_oe_o`=0.
- Writes (WDATA):
  - Byte k is captured on data edge k. Even k = upper byte `[15:8]`, odd k = lower byte `[7:0]`.
  - `hyper_rwds_i`=1 masks that byte.
  - The word is committed to memory on the odd byte, unmasked bytes only.
  - The address then advances.
- Reads (RDATA and register read):
  - In the cycle edge D+k-1 is detected (D = first data edge), register `hyper_dq_o` = byte k and `hyper_rwds_o` = ~k[0].
  - `hyper_dq_oe_o` and `hyper_rwds_oe_o` = 1 from the cycle of edge D-1 until CS rises.
  - Register-space read returns CR0 repeatedly.
  - Memory read fetches the next word when an odd byte is issued.
- Address advance:
  - Linear: +1, wraps MEM_WORDS-1 -> 0.
  - Wrapped: low 4 bits increment modulo 16 within the aligned 16-word group.
- Burst length: unbounded, terminated only by CS rising.
- CS rise in any state:
  - next cycle: FSM=IDLE, all OEs=0;
  - a pending half word (one byte received) is discarded;
  - `ca` is discarded if fewer than 6 bytes were received.
- Reset or `hyper_reset_ni` mid-transaction: aborts immediately. No memory write occurs for the current half word.

Test Plan:
- Reset with `hyper_reset_ni`=1, CS=1 -> all outputs 0, `cfg_cr0_o`=16'h8F1F, both OEs 0.
- Register write: CA 48'h6000_0100_0000, data bytes 8F,1E -> `cfg_cr0_o`=16'h8F1E, no RWDS drive after CA, rwds_oe high during CA only.
- Linear write at addr 0x10: CA 48'h2000_0002_0000, 24 latency edges, bytes AA,BB,CC,DD with RWDS=0,0,1,0 -> mem[0x10]=16'hAABB, mem[0x11] low byte=DD, upper byte unchanged.
- Linear read of same: CA 48'hA000_0002_0000 -> after 24 latency edges DQ=AA,BB,(old),DD, RWDS toggles 1,0,1,0, OEs drop the cycle after CS rises.
- Wrapped read starting addr 0x1E, 4 words -> words 0x1E,0x1F,0x10,0x11 returned. Linear read from MEM_WORDS-1 returns word 1023 then word 0.
- Abort: CS rises after 3 CA bytes, and separately after 1 write data byte -> FSM returns to IDLE, memory unchanged. A following normal read succeeds.
